// File: rtl/fp16_add_unit.sv
// fp16_add_unit: 11-stage pipelined IEEE 754 binary16 adder, round-to-nearest-even.
// One operand pair per cycle, fixed latency, no backpressure.
// Optional build macro FP16_ADD_FTZ_EN: subnormal inputs read as zero and
// subnormal results flush to zero; otherwise full gradual underflow.
module fp16_add_unit (
  input  logic        clk,
  input  logic        rstn,
  input  logic        valid_in,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] result,
  output logic        valid_out
);

  localparam int unsigned Latency = 11;
  localparam logic [15:0] QNan = 16'h7e00;

  // Special-case sideband: {override_valid, override_word}
  typedef logic [16:0] side_t;

  logic [Latency-1:0] valid_q;
  side_t              side_q [9];
  logic [8:2]         rsign_q;
  logic [8:1]         zsign_q;

  logic        s1_sa_q, s1_sb_q;
  logic [4:0]  s1_ea_q, s1_eb_q;
  logic [10:0] s1_ma_q, s1_mb_q;
  logic [4:0]  s2_e_q, s2_d_q;
  logic [10:0] s2_mb_q, s2_ms_q;
  logic        s2_sub_q;
  logic [4:0]  s3_e_q;
  logic [13:0] s3_big_q, s3_al_q;
  logic        s3_sub_q;
  logic [4:0]  s4_e_q;
  logic [14:0] s4_sum_q;
  logic [4:0]  s5_e_q;
  logic [14:0] s5_sum_q;
  logic [3:0]  s5_lz_q;
  logic [5:0]  s6_e_q;
  logic [13:0] s6_n_q;
  logic        s6_zero_q;
  logic [5:0]  s7_e_q;
  logic [11:0] s7_m_q;
  logic        s7_zero_q;
  logic [5:0]  s8_exp_q;
  logic [9:0]  s8_frac_q;
  logic        s8_zero_q;
  logic [15:0] s9_word_q, s10_word_q;

  logic        a_nan, b_nan, a_inf, b_inf, a_big, rnd_up;
  logic [4:0]  a_e, b_e;
  logic [10:0] a_m, b_m;
  side_t       side_d;
  logic [27:0] al_sh;
  logic [13:0] al;
  logic [3:0]  lz;
  logic [5:0]  lim, amt, nm_e, rn_exp;
  logic [13:0] nm_n;
  logic [9:0]  rn_frac;
  logic [15:0] pk_word;

  // Unpack: effective exponent/mantissa and an early verdict for NaN/Inf operands
  always_comb begin
    a_nan = (a[14:10] == 5'h1f) && (a[9:0] != 10'h0);
    b_nan = (b[14:10] == 5'h1f) && (b[9:0] != 10'h0);
    a_inf = (a[14:10] == 5'h1f) && (a[9:0] == 10'h0);
    b_inf = (b[14:10] == 5'h1f) && (b[9:0] == 10'h0);
    a_e   = (a[14:10] == 5'h0) ? 5'd1 : a[14:10];
    b_e   = (b[14:10] == 5'h0) ? 5'd1 : b[14:10];
`ifdef FP16_ADD_FTZ_EN
    a_m   = (a[14:10] == 5'h0) ? 11'h0 : {1'b1, a[9:0]};
    b_m   = (b[14:10] == 5'h0) ? 11'h0 : {1'b1, b[9:0]};
`else
    a_m   = {a[14:10] != 5'h0, a[9:0]};
    b_m   = {b[14:10] != 5'h0, b[9:0]};
`endif
    side_d = {1'b0, 16'h0000};
    if (a_nan || b_nan || (a_inf && b_inf && (a[15] != b[15]))) side_d = {1'b1, QNan};
    else if (a_inf) side_d = {1'b1, a[15], 15'h7c00};
    else if (b_inf) side_d = {1'b1, b[15], 15'h7c00};
  end

  // Compare, align (bits past the sticky window fold into sticky), leading-zero count
  always_comb begin
    a_big = {s1_ea_q, s1_ma_q} >= {s1_eb_q, s1_mb_q};
    al_sh = {s2_ms_q, 17'h0} >> s2_d_q;
    al    = al_sh[27:14] | {13'h0, |al_sh[13:0]};
    if (s2_d_q >= 5'd14) al = {13'h0, |s2_ms_q};
    lz = 4'd14;
    for (int i = 0; i < 14; i++) if (s4_sum_q[i]) lz = 4'(13 - i);
  end

  // Normalize (left shift clamped so the exponent never drops below 1), round, renormalize, pack
  always_comb begin
    lim = {1'b0, s5_e_q} - 6'd1;
    amt = ({2'b0, s5_lz_q} < lim) ? {2'b0, s5_lz_q} : lim;
    if (s5_sum_q[14]) begin
      nm_n = {s5_sum_q[14:2], |s5_sum_q[1:0]};
      nm_e = {1'b0, s5_e_q} + 6'd1;
    end else begin
      nm_n = s5_sum_q[13:0] << amt;
      nm_e = {1'b0, s5_e_q} - amt;
    end
    rnd_up = s6_n_q[2] & (s6_n_q[1] | s6_n_q[0] | s6_n_q[3]);
    if (s7_m_q[11]) begin
      rn_exp  = s7_e_q + 6'd1;
      rn_frac = 10'h0;
    end else begin
      // A subnormal that rounds up to 1024 becomes the smallest normal here
      rn_exp  = s7_m_q[10] ? s7_e_q : 6'd0;
      rn_frac = s7_m_q[9:0];
    end
    pk_word = {rsign_q[8], s8_exp_q[4:0], s8_frac_q};
    if (s8_zero_q) pk_word = {zsign_q[8], 15'h0};
    else if (s8_exp_q >= 6'd31) pk_word = {rsign_q[8], 15'h7c00};
`ifdef FP16_ADD_FTZ_EN
    else if (s8_exp_q == 6'd0) pk_word = {zsign_q[8], 15'h0};
`endif
  end

  // Control sideband: valid shift register, result sign, zero sign, special override
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      valid_q <= '0;
      rsign_q <= '0;
      zsign_q <= '0;
      for (int i = 0; i < 9; i++) side_q[i] <= '0;
    end else begin
      valid_q   <= {valid_q[Latency-2:0], valid_in};
      rsign_q   <= {rsign_q[7:2], a_big ? s1_sa_q : s1_sb_q};
      zsign_q   <= {zsign_q[7:1], a[15] & b[15]};
      side_q[0] <= side_d;
      for (int i = 1; i < 9; i++) side_q[i] <= side_q[i-1];
    end
  end

  // Datapath stages 1..11
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_sa_q <= 1'b0;   s1_sb_q <= 1'b0;   s1_ea_q <= '0;   s1_eb_q <= '0;
      s1_ma_q <= '0;     s1_mb_q <= '0;
      s2_e_q  <= '0;     s2_d_q  <= '0;     s2_mb_q <= '0;   s2_ms_q <= '0;
      s2_sub_q <= 1'b0;
      s3_e_q  <= '0;     s3_big_q <= '0;    s3_al_q <= '0;   s3_sub_q <= 1'b0;
      s4_e_q  <= '0;     s4_sum_q <= '0;
      s5_e_q  <= '0;     s5_sum_q <= '0;    s5_lz_q <= '0;
      s6_e_q  <= '0;     s6_n_q  <= '0;     s6_zero_q <= 1'b0;
      s7_e_q  <= '0;     s7_m_q  <= '0;     s7_zero_q <= 1'b0;
      s8_exp_q <= '0;    s8_frac_q <= '0;   s8_zero_q <= 1'b0;
      s9_word_q <= '0;   s10_word_q <= '0;  result <= '0;
    end else begin
      s1_sa_q <= a[15];  s1_sb_q <= b[15];  s1_ea_q <= a_e;  s1_eb_q <= b_e;
      s1_ma_q <= a_m;    s1_mb_q <= b_m;
      s2_e_q   <= a_big ? s1_ea_q : s1_eb_q;
      s2_d_q   <= a_big ? s1_ea_q - s1_eb_q : s1_eb_q - s1_ea_q;
      s2_mb_q  <= a_big ? s1_ma_q : s1_mb_q;
      s2_ms_q  <= a_big ? s1_mb_q : s1_ma_q;
      s2_sub_q <= s1_sa_q ^ s1_sb_q;
      s3_e_q   <= s2_e_q;
      s3_big_q <= {s2_mb_q, 3'b000};
      s3_al_q  <= al;
      s3_sub_q <= s2_sub_q;
      s4_e_q   <= s3_e_q;
      s4_sum_q <= s3_sub_q ? {1'b0, s3_big_q} - {1'b0, s3_al_q}
                           : {1'b0, s3_big_q} + {1'b0, s3_al_q};
      s5_e_q   <= s4_e_q;    s5_sum_q <= s4_sum_q;  s5_lz_q <= lz;
      s6_e_q   <= nm_e;      s6_n_q   <= nm_n;      s6_zero_q <= (s5_sum_q == 15'h0);
      s7_e_q   <= s6_e_q;    s7_zero_q <= s6_zero_q;
      s7_m_q   <= {1'b0, s6_n_q[13:3]} + {11'h0, rnd_up};
      s8_exp_q <= rn_exp;    s8_frac_q <= rn_frac;  s8_zero_q <= s7_zero_q;
      s9_word_q  <= pk_word;
      s10_word_q <= side_q[8][16] ? side_q[8][15:0] : s9_word_q;
      result     <= s10_word_q;
    end
  end

  assign valid_out = valid_q[Latency-1];

endmodule

// File: tb/tb_fp16_add_unit.sv
// tb_fp16_add_unit: directed and streaming checks for fp16_add_unit.
module tb_fp16_add_unit;

  logic        clk = 1'b0;
  logic        rstn;
  logic        valid_in;
  logic [15:0] a, b;
  logic [15:0] result;
  logic        valid_out;

  int unsigned checks = 0;
  int unsigned passes = 0;
  int unsigned cyc = 0;

  typedef struct {
    logic [15:0] want;
    int unsigned t;
  } exp_t;
  exp_t sb_q[$];

  fp16_add_unit dut (
    .clk       (clk),
    .rstn      (rstn),
    .valid_in  (valid_in),
    .a         (a),
    .b         (b),
    .result    (result),
    .valid_out (valid_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic real pow2(input int n);
    real r = 1.0;
    if (n >= 0) for (int i = 0; i < n; i++) r = r * 2.0;
    else for (int i = 0; i < -n; i++) r = r / 2.0;
    return r;
  endfunction

  function automatic real to_real(input logic [15:0] x);
    real m;
    if (x[14:10] == 5'd0) begin
`ifdef FP16_ADD_FTZ_EN
      m = 0.0;
`else
      m = real'(x[9:0]) * pow2(-24);
`endif
    end else begin
      m = real'({1'b1, x[9:0]}) * pow2(int'(x[14:10]) - 25);
    end
    return x[15] ? -m : m;
  endfunction

  // Reference: exact sum in double precision, then rounded to binary16 (RNE)
  function automatic logic [15:0] ref_add(input logic [15:0] x, input logic [15:0] y);
    logic xn, yn, xi, yi, sg;
    real  s, mag, sc, r;
    int   e, ip;
    xn = (x[14:10] == 5'h1f) && (x[9:0] != 10'h0);
    yn = (y[14:10] == 5'h1f) && (y[9:0] != 10'h0);
    xi = (x[14:10] == 5'h1f) && (x[9:0] == 10'h0);
    yi = (y[14:10] == 5'h1f) && (y[9:0] == 10'h0);
    if (xn || yn || (xi && yi && (x[15] != y[15]))) return 16'h7e00;
    if (xi) return x;
    if (yi) return y;
    s = to_real(x) + to_real(y);
    if (s == 0.0) return {x[15] & y[15], 15'h0};
    sg  = (s < 0.0);
    mag = sg ? -s : s;
    if (mag >= pow2(-14)) begin
      e = -14;
      while (e < 16 && mag >= pow2(e + 1)) e++;
      sc = mag / pow2(e - 10);
    end else begin
      e  = -15;
      sc = mag / pow2(-24);
    end
    ip = $rtoi(sc);
    r  = sc - real'(ip);
    if (r > 0.5 || (r == 0.5 && ip[0])) ip++;
    if (e == -15) begin
`ifdef FP16_ADD_FTZ_EN
      if (ip < 1024) return {x[15] & y[15], 15'h0};
`endif
      return {sg, 15'(ip)};
    end
    if (ip == 2048) begin
      ip = 1024;
      e++;
    end
    if (e > 15) return {sg, 15'h7c00};
    return {sg, 5'(e + 15), 10'(ip)};
  endfunction

  // Present one pair for one cycle and return #1 after the 11th rising edge
  task automatic apply_pair(input logic [15:0] x, input logic [15:0] y);
    @(negedge clk);
    valid_in = 1'b1;
    a = x;
    b = y;
    @(negedge clk);
    valid_in = 1'b0;
    repeat (10) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rstn = 1'b1;
    valid_in = 1'b0;
    a = 16'h0;
    b = 16'h0;
    #2 rstn = 1'b0;
    #2;
    checks++;
    if (valid_out !== 1'b0 || result !== 16'h0000)
      $display("FAIL reset_async: valid_out=%b result=%h, expected 0 and 0000", valid_out, result);
    else passes++;
    repeat (3) @(posedge clk);
    @(negedge clk) rstn = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (valid_out !== 1'b0 || result !== 16'h0000)
      $display("FAIL reset_idle: valid_out=%b result=%h, expected 0 and 0000", valid_out, result);
    else passes++;
  endtask

  task automatic test_latency();
    @(negedge clk);
    valid_in = 1'b1;
    a = 16'h3c00;
    b = 16'h3c00;
    @(negedge clk);
    valid_in = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    checks++;
    if (valid_out !== 1'b0) $display("FAIL latency_early: valid_out=%b at 10 cycles, expected 0", valid_out);
    else passes++;
    @(posedge clk);
    #1;
    checks++;
    if (valid_out !== 1'b1 || result !== 16'h4000)
      $display("FAIL latency_on_time: valid_out=%b result=%h, expected 1 and 4000", valid_out, result);
    else passes++;
    @(posedge clk);
    #1;
    checks++;
    if (valid_out !== 1'b0) $display("FAIL latency_single_pulse: valid_out=%b, expected 0", valid_out);
    else passes++;
  endtask

  // Each entry {a, b, expected}; both operand orders are checked
  task automatic test_basic();
    logic [47:0] tv [3];
    tv[0] = {16'h3c00, 16'h3c00, 16'h4000};
    tv[1] = {16'h3c00, 16'hbc00, 16'h0000};
    tv[2] = {16'h8000, 16'h8000, 16'h8000};
    for (int i = 0; i < 3; i++)
      for (int sw = 0; sw < 2; sw++) begin
        if (sw == 0) apply_pair(tv[i][47:32], tv[i][31:16]);
        else apply_pair(tv[i][31:16], tv[i][47:32]);
        checks++;
        if (valid_out !== 1'b1 || result !== tv[i][15:0])
          $display("FAIL basic[%0d] swap=%0d: valid_out=%b result=%h, expected 1 and %h",
                   i, sw, valid_out, result, tv[i][15:0]);
        else passes++;
      end
  endtask

  task automatic test_rounding();
    logic [47:0] tv [3];
    tv[0] = {16'h3c00, 16'h1000, 16'h3c00};
    tv[1] = {16'h3c01, 16'h1000, 16'h3c02};
    tv[2] = {16'h3c00, 16'h0001, 16'h3c00};
    for (int i = 0; i < 3; i++)
      for (int sw = 0; sw < 2; sw++) begin
        if (sw == 0) apply_pair(tv[i][47:32], tv[i][31:16]);
        else apply_pair(tv[i][31:16], tv[i][47:32]);
        checks++;
        if (valid_out !== 1'b1 || result !== tv[i][15:0])
          $display("FAIL rounding[%0d] swap=%0d: valid_out=%b result=%h, expected 1 and %h",
                   i, sw, valid_out, result, tv[i][15:0]);
        else passes++;
      end
  endtask

  task automatic test_specials();
    logic [47:0] tv [5];
    tv[0] = {16'h7bff, 16'h7bff, 16'h7c00};
    tv[1] = {16'h7c00, 16'hfc00, 16'h7e00};
    tv[2] = {16'h7e01, 16'h3c00, 16'h7e00};
    tv[3] = {16'hfc00, 16'h4000, 16'hfc00};
    tv[4] = {16'hfbff, 16'hfbff, 16'hfc00};
    for (int i = 0; i < 5; i++)
      for (int sw = 0; sw < 2; sw++) begin
        if (sw == 0) apply_pair(tv[i][47:32], tv[i][31:16]);
        else apply_pair(tv[i][31:16], tv[i][47:32]);
        checks++;
        if (valid_out !== 1'b1 || result !== tv[i][15:0])
          $display("FAIL specials[%0d] swap=%0d: valid_out=%b result=%h, expected 1 and %h",
                   i, sw, valid_out, result, tv[i][15:0]);
        else passes++;
      end
  endtask

  task automatic test_subnormal();
    logic [47:0] tv [2];
`ifdef FP16_ADD_FTZ_EN
    tv[0] = {16'h0001, 16'h0001, 16'h0000};
    tv[1] = {16'h03ff, 16'h0001, 16'h0000};
`else
    tv[0] = {16'h0001, 16'h0001, 16'h0002};
    tv[1] = {16'h03ff, 16'h0001, 16'h0400};
`endif
    for (int i = 0; i < 2; i++)
      for (int sw = 0; sw < 2; sw++) begin
        if (sw == 0) apply_pair(tv[i][47:32], tv[i][31:16]);
        else apply_pair(tv[i][31:16], tv[i][47:32]);
        checks++;
        if (valid_out !== 1'b1 || result !== tv[i][15:0])
          $display("FAIL subnormal[%0d] swap=%0d: valid_out=%b result=%h, expected 1 and %h",
                   i, sw, valid_out, result, tv[i][15:0]);
        else passes++;
      end
  endtask

  // 1000 random pairs, each issued in both orders, with random idle gaps
  task automatic test_streaming();
    int unsigned got = 0;
    int unsigned guard = 0;
    sb_q.delete();
    fork
      begin
        @(negedge clk);
        for (int i = 0; i < 1000; i++) begin
          logic [15:0] x, y;
          x = 16'($urandom);
          case ($urandom_range(3))
            0: y = 16'($urandom);
            1: y = {~x[15], x[14:3], 3'($urandom)};
            2: begin
              y = 16'($urandom);
              y[14:10] = x[14:10] ^ 5'($urandom_range(3));
            end
            default: begin
              x[14:10] = 5'($urandom_range(2));
              y = 16'($urandom);
              y[14:10] = 5'($urandom_range(2));
            end
          endcase
          for (int k = 0; k < 2; k++) begin
            while ($urandom_range(3) == 0) begin
              valid_in = 1'b0;
              a = 16'($urandom);
              b = 16'($urandom);
              @(negedge clk);
            end
            valid_in = 1'b1;
            a = (k == 0) ? x : y;
            b = (k == 0) ? y : x;
            sb_q.push_back('{want: ref_add(x, y), t: cyc});
            @(negedge clk);
          end
        end
        valid_in = 1'b0;
      end
      begin
        while (got < 2000 && guard < 10000) begin
          exp_t e;
          @(posedge clk);
          #1;
          guard++;
          if (valid_out === 1'b1) begin
            checks++;
            if (sb_q.size() == 0) begin
              $display("FAIL stream_unexpected: valid_out=1 result=%h, expected no output", result);
            end else begin
              e = sb_q.pop_front();
              got++;
              if (result !== e.want || cyc != e.t + 11)
                $display("FAIL stream[%0d]: result=%h at cycle %0d, expected %h at cycle %0d",
                         got - 1, result, cyc, e.want, e.t + 11);
              else passes++;
            end
          end
        end
        if (got < 2000) begin
          checks++;
          $display("FAIL stream_timeout: got %0d results, expected 2000", got);
        end
      end
    join
  endtask

  task automatic test_reset_midstream();
    logic stale = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 14; i++) begin
      valid_in = 1'b1;
      a = 16'h3c00;
      b = 16'h3c00;
      @(negedge clk);
    end
    valid_in = 1'b0;
    checks++;
    if (valid_out !== 1'b1 || result !== 16'h4000)
      $display("FAIL midreset_pre: valid_out=%b result=%h, expected 1 and 4000", valid_out, result);
    else passes++;
    #2 rstn = 1'b0;
    #1;
    checks++;
    if (valid_out !== 1'b0 || result !== 16'h0000)
      $display("FAIL midreset_async: valid_out=%b result=%h, expected 0 and 0000", valid_out, result);
    else passes++;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (valid_out !== 1'b0) stale = 1'b1;
    end
    checks++;
    if (stale) $display("FAIL midreset_stale: valid_out seen=1, expected 0 for 20 cycles");
    else passes++;
    @(negedge clk);
    valid_in = 1'b1;
    a = 16'h4000;
    b = 16'h4000;
    @(negedge clk);
    valid_in = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    checks++;
    if (valid_out !== 1'b0) $display("FAIL midreset_early: valid_out=%b, expected 0", valid_out);
    else passes++;
    @(posedge clk);
    #1;
    checks++;
    if (valid_out !== 1'b1 || result !== 16'h4400)
      $display("FAIL midreset_first: valid_out=%b result=%h, expected 1 and 4400", valid_out, result);
    else passes++;
  endtask

  initial begin
    test_reset();
    test_latency();
    test_basic();
    test_rounding();
    test_specials();
    test_subnormal();
    test_streaming();
    test_reset_midstream();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
